// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: opcode values and controller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: first iteration on the start edge, WIDTH iterations in total; done flags the last one.
// Backpressure: none; start is only honoured by the parent when it is idle.
// Ports: clk, reset (sync, active high); start, dividend, divisor in; busy, done, quotient, remainder out.
module alu_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] cur_rem, cur_quo, cur_dvsr;
    logic [CW-1:0]    cur_cnt;
    logic [WIDTH:0]   shifted, trial;

    // cnt_q holds the number of completed iterations; the W-th runs when it reads W-1.
    assign done      = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign busy      = busy_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        // On start the first iteration works directly on the fresh operands.
        cur_rem  = start ? '0       : rem_q;
        cur_quo  = start ? dividend : quo_q;
        cur_dvsr = start ? divisor  : dvsr_q;
        cur_cnt  = start ? '0       : cnt_q;
        shifted  = {cur_rem, cur_quo[WIDTH-1]};
        trial    = shifted - {1'b0, cur_dvsr};
        if (start || busy_q) begin
            dvsr_d = cur_dvsr;
            cnt_d  = cur_cnt + 1'b1;
            busy_d = !done;
            // Bit WIDTH of the trial difference is the borrow: set means restore.
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {cur_quo[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {cur_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: add/sub/mul/div/mod/and/or/xor with hi half and status flags.
// Latency: 1 cycle for everything except DIV/MOD with b!=0, which take WIDTH+1 cycles.
// Backpressure: results hold while out_valid && !out_ready; in_ready drops until the result slot frees.
// Ports: clk, reset; in_valid/in_ready with a, b, sel; out_valid/out_ready with out, out_hi,
//        carry, overflow, zero, div_by_zero.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             div_by_zero
);
    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             dbz_q, dbz_d, out_valid_q, out_valid_d;

    logic [WIDTH:0]     sum_w, dif_w;
    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH-1:0]   c_lo, c_hi;
    logic               c_carry, c_ovf, c_dbz;
    logic               accept, is_divop, div_start, div_busy, div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;

    assign in_ready = !reset && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_divop = (sel == OP_DIV) || (sel == OP_MOD);

    // Single-cycle datapath; the DIV/MOD rows are only used for the b==0 case.
    always_comb begin
        sum_w   = {1'b0, a} + {1'b0, b};
        dif_w   = {1'b0, a} - {1'b0, b};
        prod_w  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        c_lo    = '0;
        c_hi    = '0;
        c_carry = 1'b0;
        c_ovf   = 1'b0;
        c_dbz   = 1'b0;
        case (sel)
            OP_ADD: begin
                c_lo    = sum_w[WIDTH-1:0];
                c_carry = sum_w[WIDTH];
                c_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                c_lo    = dif_w[WIDTH-1:0];
                c_carry = dif_w[WIDTH];
                c_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                c_lo  = prod_w[WIDTH-1:0];
                c_hi  = prod_w[2*WIDTH-1:WIDTH];
                c_ovf = |prod_w[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                c_lo  = '1;
                c_hi  = a;
                c_dbz = 1'b1;
            end
            OP_MOD: begin
                c_lo  = a;
                c_hi  = '1;
                c_dbz = 1'b1;
            end
            OP_AND:  c_lo = a & b;
            OP_OR:   c_lo = a | b;
            OP_XOR:  c_lo = a ^ b;
            default: c_lo = '0;
        endcase
    end

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        out_d       = out_q;
        out_hi_d    = out_hi_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q && !out_ready;
        div_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = sel;
                    if (is_divop && (b != '0)) begin
                        div_start = 1'b1;
                        state_d   = ST_DIV;
                    end else begin
                        out_d       = c_lo;
                        out_hi_d    = c_hi;
                        carry_d     = c_carry;
                        ovf_d       = c_ovf;
                        zero_d      = (c_lo == '0);
                        dbz_d       = c_dbz;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_DONE;
                end else if (!div_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                out_d       = (op_q == OP_DIV) ? div_quo : div_rem;
                out_hi_d    = (op_q == OP_DIV) ? div_rem : div_quo;
                carry_d     = 1'b0;
                ovf_d       = 1'b0;
                zero_d      = (((op_q == OP_DIV) ? div_quo : div_rem) == '0);
                dbz_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            out_q       <= '0;
            out_hi_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            out_q       <= out_d;
            out_hi_q    <= out_hi_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out         = out_q;
    assign out_hi      = out_hi_q;
    assign carry       = carry_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed cases, backpressure, reset abort and random ops.
// Latency: checks 1 cycle for single-cycle ops and 9 cycles for DIV/MOD with b!=0.
// Backpressure: exercises out_ready low holds and simultaneous accept/drain.
module tb_alu_seq;
    localparam int W = 8;
    localparam int M = 256;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [2:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out, out_hi;
    logic         carry, overflow, zero, div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .sel         (sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .out_hi      (out_hi),
        .carry       (carry),
        .overflow    (overflow),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Reference: the ALU's rules in plain integer arithmetic.
    function automatic void ref_model(input int op, input int x, input int y,
                                      output int lo, output int hi, output int c,
                                      output int ov, output int dz, output int lat);
        int s;
        lo = 0; hi = 0; c = 0; ov = 0; dz = 0; lat = 1;
        case (op)
            0: begin
                lo = (x + y) % M; c = (x + y >= M) ? 1 : 0;
                s = sgn(x) + sgn(y); ov = (s > 127 || s < -128) ? 1 : 0;
            end
            1: begin
                lo = (x - y + M) % M; c = (x < y) ? 1 : 0;
                s = sgn(x) - sgn(y); ov = (s > 127 || s < -128) ? 1 : 0;
            end
            2: begin
                lo = (x * y) % M; hi = (x * y) / M; ov = (hi != 0) ? 1 : 0;
            end
            3: if (y == 0) begin lo = M - 1; hi = x; dz = 1; end
               else begin lo = x / y; hi = x % y; lat = W + 1; end
            4: if (y == 0) begin lo = x; hi = M - 1; dz = 1; end
               else begin lo = x % y; hi = x / y; lat = W + 1; end
            5: lo = x & y;
            6: lo = x | y;
            default: lo = x ^ y;
        endcase
    endfunction

    // Issue one op with out_ready high, wait (bounded) for its result and compare everything.
    task automatic run_op(input int op, input int x, input int y);
        int lo, hi, c, ov, dz, lat, cyc;
        ref_model(op, x, y, lo, hi, c, ov, dz, lat);
        sel = 3'(op); a = W'(x); b = W'(y); in_valid = 1'b1;
        #1;
        check("in_ready_before_issue", in_ready, 1);
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency", cyc, lat);
        check("out", out, lo);
        check("out_hi", out_hi, hi);
        check("carry", carry, c);
        check("overflow", overflow, ov);
        check("zero", zero, (lo == 0) ? 1 : 0);
        check("div_by_zero", div_by_zero, dz);
    endtask

    initial begin
        int x, y, op, seen, lo, hi, c, ov, dz, lat;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = '0;
        tick();
        tick();
        check("in_ready_in_reset", in_ready, 0);
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_out_hi", out_hi, 0);
        check("rst_flags", {carry, overflow, zero, div_by_zero}, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed arithmetic
        run_op(0, 200, 100); check("add_const", out, 44);  check("add_carry", carry, 1);
        run_op(1, 5, 7);     check("sub_const", out, 254); check("sub_borrow", carry, 1);
        run_op(0, 100, 100); check("add_ovf_const", overflow, 1);
        run_op(2, 20, 15);   check("mul_hi_const", out_hi, 1);
        run_op(2, 3, 4);     check("mul_const", out, 12);
        run_op(3, 9, 0);     check("div0_const", out, 255);
        run_op(4, 9, 0);     check("mod0_const", out_hi, 255);

        // DIV with the consumer stalled: in_ready low through cycles 1..9, result in cycle 9
        tick();
        out_ready = 1'b0;
        sel = 3'(3); a = 8'd200; b = 8'd7; in_valid = 1'b1;
        #1;
        check("div_in_ready_issue", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            check("div_in_ready_busy", in_ready, 0);
            check("div_out_valid_timing", out_valid, (k == 9) ? 1 : 0);
            if (k < 9) tick();
        end
        check("div_quotient", out, 28);
        check("div_remainder", out_hi, 4);
        out_ready = 1'b1;
        run_op(4, 200, 7);   check("mod_const", out, 4);

        // Backpressure hold on an AND result
        tick();
        out_ready = 1'b0;
        sel = 3'(5); a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_out", out, 0);
            check("hold_zero", zero, 1);
            check("hold_in_ready", in_ready, 0);
            tick();
        end
        // Accept and drain on the same edge
        x = int'($urandom_range(0, 255)); y = int'($urandom_range(0, 255));
        sel = 3'(7); a = W'(x); b = W'(y); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("concurrent_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("concurrent_out_valid", out_valid, 1);
        check("concurrent_out", out, x ^ y);

        // Back-to-back single-cycle ops: one result per cycle
        for (int i = 0; i < 20; i++) begin
            op = int'($urandom_range(0, 5));
            if (op >= 3) op = op + 2;
            x = int'($urandom_range(0, 255)); y = int'($urandom_range(0, 255));
            ref_model(op, x, y, lo, hi, c, ov, dz, lat);
            sel = 3'(op); a = W'(x); b = W'(y); in_valid = 1'b1;
            #1;
            check("b2b_in_ready", in_ready, 1);
            tick();
            check("b2b_out_valid", out_valid, 1);
            check("b2b_out", out, lo);
            check("b2b_out_hi", out_hi, hi);
        end
        in_valid = 1'b0;
        tick();

        // Reset in the middle of a division aborts it
        sel = 3'(3); a = 8'd250; b = 8'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen = 1;
            tick();
        end
        check("abort_no_result", seen, 0);
        run_op(0, 1, 1);     check("post_reset_add", out, 2);

        // Random ops across all opcodes, occasional zero divisor
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 7));
            x  = int'($urandom_range(0, 255));
            y  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            run_op(op, x, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 4-bit registered ALU.
- Performs add, subtract, multiply, divide, modulo and bitwise ops on WIDTH-bit unsigned operands.
- Produces a full-width result, a high/aux half and status flags.
- Sits between an operand-issuing controller and a result consumer, with valid/ready on both sides. Division is iterative and multi-cycle; every other op takes one cycle.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept an op this cycle
- a  in  WIDTH  operand A (unsigned; signed view used only for overflow)
- b  in  WIDTH  operand B
- sel  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 AND, 110 OR, 111 XOR
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts the result
- out  out  WIDTH  primary result
- out_hi  out  WIDTH  MUL: high half of product; DIV/MOD: remainder/quotient (the other half); others: 0
- carry  out  1  ADD: carry-out; SUB: borrow (a<b); else 0
- overflow  out  1  ADD/SUB: two's-complement signed overflow; MUL: out_hi != 0; else 0
- zero  out  1  out == 0
- div_by_zero  out  1  DIV/MOD issued with b == 0

Behaviour:
- Reset: state IDLE, in_ready=0 during reset cycle then 1, out_valid=0, out/out_hi=0, all flags=0. Reset mid-division aborts it; no result is emitted.
- Accept: handshake fires when in_valid && in_ready at a rising edge; a, b and sel are captured at that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept and output drain can occur in the same cycle.
- FSM states: IDLE, DIV, DONE.
  - IDLE, on accept with non-DIV/MOD op, or DIV/MOD with b==0: compute combinationally, register results, out_valid=1 next edge. Latency 1; state stays IDLE.
  - IDLE, on accept with DIV/MOD and b!=0: load divider, go to DIV. The restoring divider takes one quotient bit per cycle, MSB first, for WIDTH cycles.
  - DIV to DONE after the WIDTH-th iteration.
  - DONE: register quotient/remainder, set out_valid, go to IDLE.
  - Total latency from accept to out_valid is WIDTH+1 cycles.
- Output hold: out, out_hi and flags are stable while out_valid && !out_ready. out_valid clears on out_ready unless a new result loads at the same edge.
- Arithmetic:
  - ADD/SUB use WIDTH+1-bit intermediates; out is the low WIDTH bits, wrapping.
  - MUL uses a 2*WIDTH product: out = low half, out_hi = high half.
  - DIV: out = quotient, out_hi = remainder. MOD: out = remainder, out_hi = quotient.
- Divide by zero: out = all ones for DIV, a for MOD; out_hi = a for DIV, all ones for MOD; div_by_zero=1; latency 1; no DIV state entered.
- zero is computed on the final out value.
- Ops never overlap: at most one op is in flight; in_ready=0 throughout DIV/DONE.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD..OP_XOR (3-bit)
  - FSM state encoding IDLE/DIV/DONE
- Sub-module alu_divider (WIDTH parameter): start/busy/done, dividend, divisor, quotient, remainder; iterative restoring algorithm.
- alu_seq instantiates it and keeps the handshake, single-cycle datapath and output registers.

Test Plan (WIDTH=8):
- ADD/SUB: ADD a=200, b=100 -> out=44, carry=1, overflow=0, latency 1. SUB a=5, b=7 -> out=254, carry=1. ADD a=100, b=100 -> out=200, overflow=1.
- MUL a=20, b=15 -> out=44, out_hi=1, overflow=1. MUL a=3, b=4 -> out=12, out_hi=0, overflow=0, zero=0.
- DIV a=200, b=7 -> out_valid exactly 9 cycles after accept, out=28, out_hi=4. in_ready=0 for cycles 1..9. MOD same operands -> out=4, out_hi=28.
- Divide by zero: DIV a=9, b=0 -> out=255, out_hi=9, div_by_zero=1, latency 1. MOD a=9, b=0 -> out=9, out_hi=255.
- Backpressure:
  - hold out_ready=0 for 5 cycles after AND a=0xF0, b=0x0F -> out=0, zero=1 stable, in_ready=0.
  - raise out_ready together with a new in_valid XOR -> both handshakes complete on one edge.
  - back-to-back ops then sustain 1 result/cycle.
- Reset mid-op: assert reset at cycle 4 of a DIV -> next cycle out_valid=0, state IDLE, in_ready=1 after reset deasserts. A following ADD 1+1 -> out=2.
